// File: rtl/binconv_stream_engine.sv
// ---------------------------------------------------------------------------
// binconv_stream_engine
//
// Binary 5x5 convolution engine. Latches one 25-bit kernel from the kernel
// reader and streams a 1-bit IMG_H x IMG_W image from a synchronous image
// RAM. For every valid 5x5 window position it emits the number of matching
// bits between the window and the kernel, which is popcount(XNOR). When a
// pass is complete it requests the next kernel. It stops after N_KERNELS
// passes, or earlier if the reader reports that every kernel has been read.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   start        one-cycle run request, honoured in IDLE and DONE
//   kernal_data  kernel bits, bit 5*i+j = row i (0 = top), column j (0 = left)
//   kernal_num   index of the kernel currently on kernal_data
//   kern_ready   reader's per-kernel finished flag
//   kern_all     reader's all-kernels-read flag
//   kern_req     one-cycle request for the next kernel
//   img_addr     image RAM read address, row-major
//   img_data     image RAM read data, valid one cycle after its address
//   conv_valid   one-cycle result strobe
//   conv_data    match count 0..25
//   conv_row     output row of the result
//   conv_col     output column of the result
//   conv_kernal  kernel index latched for the current pass
//   busy         run in progress
//   done         run finished, held until the next start or reset
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | after reset, waiting for start
// S_WAIT_K | waiting for a kernel (kern_ready) or the end of kernels (kern_all)
// S_STREAM | issuing image addresses 0 .. IMG_W*IMG_H-1
// S_FLUSH  | two cycles so the last pixel can reach the result register
// S_REQ    | one-cycle kern_req pulse to the reader
// S_GUARD  | one cycle in which the reader still shows its stale done flag
// S_DONE   | run complete
// ---------------------------------------------------------------------------
module binconv_stream_engine #(
   parameter int IMG_W     = 28,
   parameter int IMG_H     = 28,
   parameter int N_KERNELS = 32,
   parameter int ADDR_W    = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [24:0]       kernal_data,
   input  logic [5:0]        kernal_num,
   input  logic              kern_ready,
   input  logic              kern_all,
   output logic              kern_req,
   output logic [ADDR_W-1:0] img_addr,
   input  logic              img_data,
   output logic              conv_valid,
   output logic [4:0]        conv_data,
   output logic [4:0]        conv_row,
   output logic [4:0]        conv_col,
   output logic [5:0]        conv_kernal,
   output logic              busy,
   output logic              done
);

   localparam int RW     = $clog2(IMG_H);
   localparam int CW     = $clog2(IMG_W);
   localparam int NPIX   = IMG_W * IMG_H;
   // Four full previous rows plus the four pixels before the current one.
   localparam int LB_LEN = 4 * IMG_W + 4;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_K,
      S_STREAM,
      S_FLUSH,
      S_REQ,
      S_GUARD,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [ADDR_W-1:0] r_addr;
   logic [RW-1:0]     r_row;
   logic [CW-1:0]     r_col;
   logic              r_pix_vld;
   logic [RW-1:0]     r_pix_row;
   logic [CW-1:0]     r_pix_col;
   logic [LB_LEN-1:0] r_lb;
   logic [24:0]       r_kernel;
   logic [5:0]        r_kern_num;
   logic [5:0]        r_kcnt;
   logic              r_flush_cnt;
   logic              r_conv_valid;
   logic [4:0]        r_conv_data;
   logic [4:0]        r_conv_row;
   logic [4:0]        r_conv_col;

   logic              w_last_addr;
   logic              w_flush_end;
   logic [5:0]        w_kcnt_inc;
   logic              w_last_kern;
   logic              w_take_kernel;
   logic              w_start_run;
   logic              w_win_ok;
   logic [24:0]       w_win;
   logic [24:0]       w_match;
   logic [4:0]        w_pop;

   assign w_last_addr   = (r_addr == LAST_ADDR);
   assign w_flush_end   = (r_flush_cnt == 1'b0);
   assign w_kcnt_inc    = r_kcnt + 1'b1;
   assign w_last_kern   = (w_kcnt_inc == 6'(N_KERNELS));
   // kern_all has priority over kern_ready.
   assign w_take_kernel = (r_state == S_WAIT_K) && !kern_all && kern_ready;
   assign w_start_run   = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;

   // -------------------------------------------------------------------------
   // Window extraction. r_lb[0] is the pixel that arrived one cycle before
   // img_data, so pixel (r-a, c-b) sits a*IMG_W + b positions back. Window
   // bit 5*i+j = pixel (r-4+i, c-4+j).
   // -------------------------------------------------------------------------
   for (genvar gi = 0; gi < 5; gi++) begin : g_row
      for (genvar gj = 0; gj < 5; gj++) begin : g_col
         localparam int OFF = (4 - gi) * IMG_W + (4 - gj);
         if (OFF == 0) begin : g_cur
            assign w_win[5*gi+gj] = img_data;
         end else begin : g_lb
            assign w_win[5*gi+gj] = r_lb[OFF-1];
         end
      end
   end

   assign w_match = ~(w_win ^ r_kernel);

   always_comb begin
      w_pop = '0;
      for (int k = 0; k < 25; k++) begin
         w_pop = w_pop + 5'(w_match[k]);
      end
   end

   // Windows are not formed across a row wrap; c < 4 or r < 4 gives nothing.
   assign w_win_ok = r_pix_vld && (r_pix_row >= RW'(4)) && (r_pix_col >= CW'(4));

   // -------------------------------------------------------------------------
   // FSM next state and outputs
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      kern_req    = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_nxt = S_WAIT_K;
         end
         S_WAIT_K: begin
            busy = 1'b1;
            if (kern_all)        w_state_nxt = S_DONE;
            else if (kern_ready) w_state_nxt = S_STREAM;
         end
         S_STREAM: begin
            busy = 1'b1;
            if (w_last_addr) w_state_nxt = S_FLUSH;
         end
         S_FLUSH: begin
            busy = 1'b1;
            if (w_flush_end) w_state_nxt = w_last_kern ? S_DONE : S_REQ;
         end
         S_REQ: begin
            busy        = 1'b1;
            kern_req    = 1'b1;
            w_state_nxt = S_GUARD;
         end
         S_GUARD: begin
            busy        = 1'b1;
            w_state_nxt = S_WAIT_K;
         end
         S_DONE: begin
            done = 1'b1;
            if (start) w_state_nxt = S_WAIT_K;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // State and datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_addr       <= '0;
         r_row        <= '0;
         r_col        <= '0;
         r_pix_vld    <= 1'b0;
         r_pix_row    <= '0;
         r_pix_col    <= '0;
         r_lb         <= '0;
         r_kernel     <= '0;
         r_kern_num   <= '0;
         r_kcnt       <= '0;
         r_flush_cnt  <= 1'b0;
         r_conv_valid <= 1'b0;
         r_conv_data  <= '0;
         r_conv_row   <= '0;
         r_conv_col   <= '0;
      end else begin
         r_state <= w_state_nxt;

         if (w_take_kernel) begin
            r_kernel   <= kernal_data;
            r_kern_num <= kernal_num;
            r_addr     <= '0;
            r_row      <= '0;
            r_col      <= '0;
         end else if ((r_state == S_STREAM) && !w_last_addr) begin
            r_addr <= r_addr + 1'b1;
            if (r_col == CW'(IMG_W - 1)) begin
               r_col <= '0;
               r_row <= r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end

         // The RAM returns data one cycle after the address, so the issue
         // counters are delayed once to tag the arriving pixel.
         r_pix_vld <= (r_state == S_STREAM);
         r_pix_row <= r_row;
         r_pix_col <= r_col;

         if (r_pix_vld) begin
            r_lb <= {r_lb[LB_LEN-2:0], img_data};
         end

         r_conv_valid <= w_win_ok;
         if (w_win_ok) begin
            r_conv_data <= w_pop;
            r_conv_row  <= 5'(r_pix_row - RW'(4));
            r_conv_col  <= 5'(r_pix_col - CW'(4));
         end

         if (r_state == S_STREAM) begin
            r_flush_cnt <= 1'b1;
         end else if (r_state == S_FLUSH) begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
         end

         if (w_start_run) begin
            r_kcnt <= '0;
         end else if ((r_state == S_FLUSH) && w_flush_end) begin
            r_kcnt <= w_kcnt_inc;
         end
      end
   end

   assign img_addr    = r_addr;
   assign conv_valid  = r_conv_valid;
   assign conv_data   = r_conv_data;
   assign conv_row    = r_conv_row;
   assign conv_col    = r_conv_col;
   assign conv_kernal = r_kern_num;

endmodule

// File: tb/tb_binconv_stream_engine.sv
module tb_binconv_stream_engine;

   localparam int IMG_W = 28;
   localparam int IMG_H = 28;
   localparam int NK    = 32;
   localparam int AW    = 10;
   localparam int NPIX  = IMG_W * IMG_H;
   localparam int OH    = IMG_H - 4;
   localparam int OW    = IMG_W - 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [24:0]   kernal_data;
   logic [5:0]    kernal_num;
   logic          kern_ready;
   logic          kern_all;
   logic          kern_req;
   logic [AW-1:0] img_addr;
   logic          img_data;
   logic          conv_valid;
   logic [4:0]    conv_data;
   logic [4:0]    conv_row;
   logic [4:0]    conv_col;
   logic [5:0]    conv_kernal;
   logic          busy;
   logic          done;

   always #5 clk = ~clk;

   binconv_stream_engine #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .N_KERNELS(NK), .ADDR_W(AW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .kernal_data(kernal_data), .kernal_num(kernal_num),
      .kern_ready(kern_ready), .kern_all(kern_all), .kern_req(kern_req),
      .img_addr(img_addr), .img_data(img_data),
      .conv_valid(conv_valid), .conv_data(conv_data), .conv_row(conv_row),
      .conv_col(conv_col), .conv_kernal(conv_kernal),
      .busy(busy), .done(done)
   );

   // synchronous 1-bit image RAM
   logic mem [0:NPIX-1];
   always @(posedge clk) img_data <= (int'(img_addr) < NPIX) ? mem[img_addr] : 1'b0;

   int total = 0;
   int bad   = 0;
   int n_req;
   int n_cv;

   typedef struct packed {
      logic [4:0] d;
      logic [4:0] r;
      logic [4:0] c;
      logic [5:0] k;
   } exp_t;
   exp_t q[$];

   // reader model controls
   int          rd_limit;
   logic [24:0] rd_kbase;
   bit          rd_vary;
   bit          rd_restart;
   int          rd_idx;
   int          rd_phase;
   int          rd_cnt;
   bit          rd_loading;

   function automatic logic [24:0] kern_of(input int idx);
      logic [24:0] v;
      v = rd_kbase;
      if (rd_vary) v = v ^ 25'(idx * 32'h0013579 + idx * 7);
      return v;
   endfunction

   // Reader: keeps its stale done flag through the GUARD cycle, then loads
   // for 52 cycles with junk on the data lines before showing the next kernel.
   always @(negedge clk) begin
      if (rd_restart) begin
         rd_restart  = 1'b0;
         rd_idx      = 0;
         rd_phase    = 0;
         rd_loading  = 1'b0;
         kern_all    = 1'b0;
         kern_ready  = 1'b1;
         kernal_data = kern_of(0);
         kernal_num  = 6'd0;
      end else if (kern_req) begin
         n_req++;
         rd_phase = 1;
      end else if (rd_phase == 1) begin
         rd_phase   = 0;
         rd_loading = 1'b1;
         rd_cnt     = 52;
         rd_idx++;
      end else if (rd_loading) begin
         kern_ready  = 1'b0;
         kernal_data = 25'($urandom);
         kernal_num  = 6'($urandom);
         rd_cnt--;
         if (rd_cnt == 0) begin
            rd_loading = 1'b0;
            kern_ready = 1'b1;
            if (rd_idx >= rd_limit) begin
               kern_all = 1'b1;
            end else begin
               kernal_data = kern_of(rd_idx);
               kernal_num  = 6'(rd_idx);
            end
         end
      end
   end

   // scoreboard consumer
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && conv_valid) begin
         n_cv++;
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL extra_result: got d=%0d r=%0d c=%0d k=%0d, expected no result",
                     conv_data, conv_row, conv_col, conv_kernal);
         end else begin
            e = q.pop_front();
            if ({conv_data, conv_row, conv_col, conv_kernal} !== {e.d, e.r, e.c, e.k}) begin
               bad++;
               $display("FAIL result: got d=%0d r=%0d c=%0d k=%0d, expected d=%0d r=%0d c=%0d k=%0d",
                        conv_data, conv_row, conv_col, conv_kernal, e.d, e.r, e.c, e.k);
            end
         end
      end
   end

   task automatic push_expected(input int npass);
      exp_t        e;
      logic [24:0] k;
      int          d;
      for (int p = 0; p < npass; p++) begin
         k = kern_of(p);
         for (int r = 0; r < OH; r++) begin
            for (int c = 0; c < OW; c++) begin
               d = 0;
               for (int i = 0; i < 5; i++)
                  for (int j = 0; j < 5; j++)
                     if (mem[(r + i) * IMG_W + c + j] == k[5*i+j]) d++;
               e.d = 5'(d);
               e.r = 5'(r);
               e.c = 5'(c);
               e.k = 6'(p);
               q.push_back(e);
            end
         end
      end
   endtask

   task automatic fill_mem(input int mode);
      for (int a = 0; a < NPIX; a++) mem[a] = (mode == 1) ? 1'($urandom) : 1'b0;
   endtask

   task automatic begin_run(input int limit, input int npass);
      rd_limit = limit;
      q.delete();
      push_expected(npass);
      n_req = 0;
      n_cv  = 0;
      rd_restart = 1'b1;
      @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc, input bit poke_start,
                            output int t116, output int tcv);
      t116 = -1;
      tcv  = -1;
      for (int cyc = 0; cyc < max_cyc; cyc++) begin
         @(negedge clk);
         start = poke_start && (cyc == 1000);
         if (t116 < 0 && busy && img_addr == AW'(116)) t116 = cyc;
         if (tcv < 0 && conv_valid) tcv = cyc;
         if (done) break;
      end
      start = 1'b0;
   endtask

   task automatic check_end(input string name, input int exp_cv, input int exp_req);
      total++;
      if ({done, busy} !== 2'b10) begin
         bad++;
         $display("FAIL %s_done: got done=%0b busy=%0b, expected done=1 busy=0", name, done, busy);
      end
      total++;
      if (n_cv !== exp_cv) begin
         bad++;
         $display("FAIL %s_count: got %0d results, expected %0d", name, n_cv, exp_cv);
      end
      total++;
      if (n_req !== exp_req) begin
         bad++;
         $display("FAIL %s_req: got %0d kern_req pulses, expected %0d", name, n_req, exp_req);
      end
      total++;
      if (q.size() !== 0) begin
         bad++;
         $display("FAIL %s_left: got %0d results missing, expected 0", name, q.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({kern_req, img_addr, conv_valid, conv_data, conv_row, conv_col, conv_kernal, busy, done} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got addr=%0d cv=%0b kern=%0d busy=%0b done=%0b req=%0b, expected all 0",
                  img_addr, conv_valid, conv_kernal, busy, done, kern_req);
      end
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if ({busy, done} !== 2'b00) begin
         bad++;
         $display("FAIL idle_flags: got busy=%0b done=%0b, expected 0 0", busy, done);
      end
   endtask

   task automatic test_zero_kernel();
      int t116, tcv;
      fill_mem(0);
      rd_kbase = 25'h0;
      rd_vary  = 1'b0;
      begin_run(1, 1);
      wait_done(2000, 1'b0, t116, tcv);
      check_end("zero_kernel", OH * OW, 1);
   endtask

   task automatic test_ones_kernel();
      int t116, tcv;
      fill_mem(0);
      rd_kbase = 25'h1FFFFFF;
      rd_vary  = 1'b0;
      begin_run(1, 1);
      wait_done(2000, 1'b0, t116, tcv);
      check_end("ones_kernel", OH * OW, 1);
      total++;
      if (t116 < 0 || tcv < 0 || (tcv - t116) !== 2) begin
         bad++;
         $display("FAIL latency: got addr116 at %0d first result at %0d, expected gap 2", t116, tcv);
      end
   endtask

   task automatic test_single_pixel();
      int t116, tcv;
      fill_mem(0);
      mem[10 * IMG_W + 10] = 1'b1;
      rd_kbase = 25'h1FFFFFF;
      rd_vary  = 1'b0;
      begin_run(1, 1);
      wait_done(2000, 1'b0, t116, tcv);
      check_end("single_pixel", OH * OW, 1);
   endtask

   task automatic test_handshake();
      int t116, tcv;
      fill_mem(1);
      rd_kbase = 25'h0A5C3F1;
      rd_vary  = 1'b1;
      begin_run(NK, NK);
      wait_done(NK * 900 + 500, 1'b1, t116, tcv);
      check_end("handshake", NK * OH * OW, NK - 1);
   endtask

   task automatic test_kern_all();
      int t116, tcv;
      fill_mem(1);
      rd_kbase = 25'h1234567;
      rd_vary  = 1'b1;
      begin_run(3, 3);
      wait_done(4000, 1'b0, t116, tcv);
      check_end("kern_all", 3 * OH * OW, 3);
      repeat (100) @(negedge clk);
      total++;
      if (n_req !== 3 || done !== 1'b1) begin
         bad++;
         $display("FAIL kern_all_idle: got req=%0d done=%0b, expected req=3 done=1", n_req, done);
      end
   endtask

   task automatic test_reset_mid();
      int  t116, tcv;
      bit  hit;
      fill_mem(1);
      rd_kbase = 25'h1C0FFEE;
      rd_vary  = 1'b1;
      begin_run(NK, NK);
      hit = 1'b0;
      for (int cyc = 0; cyc < 2000 && !hit; cyc++) begin
         @(negedge clk);
         if (img_addr == AW'(300)) hit = 1'b1;
      end
      total++;
      if (!hit) begin
         bad++;
         $display("FAIL mid_wait: got no img_addr 300 in 2000 cycles, expected it");
      end
      rst_n = 1'b0;
      q.delete();
      @(negedge clk);
      total++;
      if ({kern_req, img_addr, conv_valid, conv_data, conv_row, conv_col, conv_kernal, busy, done} !== '0) begin
         bad++;
         $display("FAIL mid_reset_outputs: got addr=%0d cv=%0b kern=%0d busy=%0b done=%0b, expected all 0",
                  img_addr, conv_valid, conv_kernal, busy, done);
      end
      rst_n = 1'b1;
      n_cv = 0;
      repeat (5) @(negedge clk);
      total++;
      if (n_cv !== 0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL post_reset_quiet: got %0d results busy=%0b, expected 0 0", n_cv, busy);
      end
      begin_run(1, 1);
      wait_done(2000, 1'b0, t116, tcv);
      check_end("restart", OH * OW, 1);
   endtask

   initial begin
      rst_n       = 1'b0;
      start       = 1'b0;
      kernal_data = '0;
      kernal_num  = '0;
      kern_ready  = 1'b0;
      kern_all    = 1'b0;
      rd_limit    = 0;
      rd_kbase    = '0;
      rd_vary     = 1'b0;
      rd_restart  = 1'b0;
      rd_idx      = 0;
      rd_phase    = 0;
      rd_cnt      = 0;
      rd_loading  = 1'b0;
      n_req       = 0;
      n_cv        = 0;
      fill_mem(0);

      test_reset();
      test_zero_kernel();
      test_ones_kernel();
      test_single_pixel();
      test_handshake();
      test_kern_all();
      test_reset_mid();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
